fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/DE pipeline register.
- Issues in-order word requests to a variable-latency instruction memory over a valid/ready interface.
- Buffers returned instructions, each with its PC+4, in a DEPTH-entry FIFO.
- Presents the FIFO head to decode and honours the decode stall (deq_ready = ~stall).
- On a taken branch (redirect), flushes buffered and in-flight fetches and restarts at the target.

---
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues in-order word requests, buffers responses with PC+1 in a
// DEPTH-entry FIFO for decode, and flushes on redirect while dropping stale in-flight responses.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h100000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [29:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  input  logic        deq_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] inst_pc_plus4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthC = (CW + 1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic [29:0] resp_pc_q, resp_pc_d;
  cnt_t        count_q, count_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_cnt_q, drop_cnt_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;

  logic [31:0] fifo_inst_q [DEPTH];
  logic [29:0] fifo_pc_q   [DEPTH];

  logic [CW:0] credit_used;
  logic        req_fire, resp_fire, drop, enq, deq;

  // Buffered plus in-flight entries must fit the FIFO, so a response always has a slot.
  assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = reset & ~redirect & (credit_used < DepthC);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire  = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_fire = imem_resp_valid & (outstanding_q != '0);
  assign drop      = resp_fire & (drop_cnt_q != '0);
  assign enq       = resp_fire & ~drop & ~redirect;
  assign deq       = inst_valid & deq_ready & ~redirect;

  assign inst_valid    = (count_q != '0);
  assign inst          = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign inst_pc_plus4 = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(resp_fire);
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_d = outstanding_q - cnt_t'(resp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 30'd1;
      if (drop) drop_cnt_d = drop_cnt_q - cnt_t'(1);
      if (enq) begin
        resp_pc_d = resp_pc_q + 30'd1;
        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(enq) - cnt_t'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked by inst_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_inst_q[wr_ptr_q] <= imem_resp_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q + 30'd1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a variable-latency memory plus a stream-level model (expected queue
// contents, epoch-tagged requests) checked every cycle under directed and random stimulus.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [29:0] RESET_PC = 30'h100000;

  typedef struct {
    logic [29:0] addr;
    int          epoch;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [29:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect = 1'b0;
  logic [29:0] redirect_pc = '0;
  logic        deq_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc_plus4;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int epoch    = 0;
  int lat      = 1;
  logic fired;

  // Model state: what the queue should hold, and what the memory still owes.
  logic [31:0] buf_inst[$];
  logic [29:0] buf_pc[$];
  req_t        pending[$];
  logic [29:0] exp_fetch_pc, exp_resp_pc;

  logic        exp_req_valid, exp_inst_valid;
  logic [29:0] exp_req_addr, exp_pc4;
  logic [31:0] exp_inst;
  logic        obs_req_valid, obs_inst_valid;
  logic [29:0] obs_req_addr, obs_pc4;
  logic [31:0] obs_inst;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic model_reset();
    pending.delete();
    buf_inst.delete();
    buf_pc.delete();
    epoch++;
    exp_fetch_pc    = RESET_PC;
    exp_resp_pc     = RESET_PC;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    redirect  = 1'b0;
    deq_ready = 1'b1;
    imem_req_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One clock cycle: drive memory, sample at negedge, advance the model. Entered/left at posedge+1.
  task automatic tick();
    logic  deq_now;
    req_t  r;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pending[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    @(negedge clk);
    exp_req_valid  = !redirect && (buf_inst.size() + pending.size() < DEPTH);
    exp_req_addr   = exp_fetch_pc;
    exp_inst_valid = (buf_inst.size() != 0);
    exp_inst       = exp_inst_valid ? buf_inst[0] : '0;
    exp_pc4        = exp_inst_valid ? buf_pc[0] : '0;
    obs_req_valid  = imem_req_valid;
    obs_req_addr   = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_inst       = inst;
    obs_pc4        = inst_pc_plus4;
    fired   = imem_req_valid && imem_req_ready;
    deq_now = !redirect && deq_ready && (buf_inst.size() != 0);
    if (imem_resp_valid) begin
      r = pending.pop_front();
      if (!redirect && r.epoch == epoch) begin
        buf_inst.push_back(mem_word(exp_resp_pc));
        buf_pc.push_back(exp_resp_pc + 30'd1);
        exp_resp_pc = exp_resp_pc + 30'd1;
      end
    end
    if (deq_now) begin
      void'(buf_inst.pop_front());
      void'(buf_pc.pop_front());
    end
    if (fired) begin
      pending.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + lat});
      exp_fetch_pc = exp_fetch_pc + 30'd1;
    end
    if (redirect) begin
      epoch++;
      buf_inst.delete();
      buf_pc.delete();
      exp_fetch_pc = redirect_pc;
      exp_resp_pc  = redirect_pc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_req_ready = 1'b1;
    deq_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst); else n_pass++;
    n_checks++; if (inst_pc_plus4 !== 30'h0) $display("FAIL rst_pc4: got %h want 0", inst_pc_plus4); else n_pass++;
    reset = 1'b1;
    lat = 1;
    tick();
    n_checks++; if (obs_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", obs_req_valid); else n_pass++;
    n_checks++; if (obs_req_addr !== RESET_PC) $display("FAIL first_req_addr: got %h want %h", obs_req_addr, RESET_PC); else n_pass++;
  endtask

  task automatic test_stream();
    logic seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (obs_req_valid !== exp_req_valid) $display("FAIL stream_req_valid: got %b want %b", obs_req_valid, exp_req_valid); else n_pass++;
      if (exp_req_valid) begin
        n_checks++; if (obs_req_addr !== exp_req_addr) $display("FAIL stream_req_addr: got %h want %h", obs_req_addr, exp_req_addr); else n_pass++;
      end
      n_checks++; if (obs_inst !== exp_inst) $display("FAIL stream_inst: got %h want %h", obs_inst, exp_inst); else n_pass++;
      n_checks++; if (obs_pc4 !== exp_pc4) $display("FAIL stream_pc4: got %h want %h", obs_pc4, exp_pc4); else n_pass++;
      if (seen) begin
        n_checks++; if (obs_inst_valid !== 1'b1) $display("FAIL stream_gap: got %b want 1", obs_inst_valid); else n_pass++;
      end else if (obs_inst_valid) begin
        seen = 1'b1;
        n_checks++; if (obs_pc4 !== RESET_PC + 30'd1) $display("FAIL stream_first_pc4: got %h want %h", obs_pc4, RESET_PC + 30'd1); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    int          fires = 0;
    logic [31:0] head  = '0;
    logic        have_head = 1'b0;
    apply_reset();
    lat = 1;
    deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fired) fires++;
      if (obs_inst_valid && !have_head) begin
        head = obs_inst;
        have_head = 1'b1;
      end
      n_checks++; if (obs_inst !== exp_inst) $display("FAIL stall_inst: got %h want %h", obs_inst, exp_inst); else n_pass++;
    end
    n_checks++; if (fires != DEPTH) $display("FAIL stall_fires: got %0d want %0d", fires, DEPTH); else n_pass++;
    n_checks++; if (obs_inst_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", obs_inst_valid); else n_pass++;
    n_checks++; if (obs_inst !== head || !have_head) $display("FAIL stall_head: got %h want %h", obs_inst, head); else n_pass++;
    deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_checks++; if (obs_inst_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b want 1", i, obs_inst_valid); else n_pass++;
      n_checks++; if (obs_inst !== mem_word(RESET_PC + 30'(i))) $display("FAIL drain_inst[%0d]: got %h want %h", i, obs_inst, mem_word(RESET_PC + 30'(i))); else n_pass++;
      n_checks++; if (obs_pc4 !== RESET_PC + 30'(i + 1)) $display("FAIL drain_pc4[%0d]: got %h want %h", i, obs_pc4, RESET_PC + 30'(i + 1)); else n_pass++;
    end
  endtask

  task automatic test_redirect_stale();
    logic found = 1'b0;
    apply_reset();
    lat = 3;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 30'h200;
    tick();
    redirect = 1'b0;
    n_checks++; if (obs_req_valid !== 1'b0) $display("FAIL stale_req_suppressed: got %b want 0", obs_req_valid); else n_pass++;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (!exp_inst_valid) begin
        n_checks++; if (obs_inst_valid !== 1'b0) $display("FAIL stale_leak: got %b want 0 (inst %h)", obs_inst_valid, obs_inst); else n_pass++;
      end
      if (obs_inst_valid) begin
        found = 1'b1;
        n_checks++; if (obs_inst !== mem_word(30'h200)) $display("FAIL stale_inst: got %h want %h", obs_inst, mem_word(30'h200)); else n_pass++;
        n_checks++; if (obs_pc4 !== 30'h201) $display("FAIL stale_pc4: got %h want 201", obs_pc4); else n_pass++;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL stale_timeout: got no inst want inst at 200");
    end
  endtask

  task automatic test_redirect_resp();
    int found = 0;
    apply_reset();
    lat = 1;
    deq_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (buf_inst.size() == 3 && pending.size() > 0 && pending[0].due <= cyc) break;
      tick();
    end
    redirect = 1'b1;
    redirect_pc = 30'h3FFF_FFFE;
    deq_ready = 1'b1;
    tick();
    redirect = 1'b0;
    n_checks++; if (obs_inst_valid !== 1'b1) $display("FAIL rr_count3: got %b want 1", obs_inst_valid); else n_pass++;
    tick();
    n_checks++; if (obs_inst_valid !== 1'b0) $display("FAIL rr_flush: got %b want 0", obs_inst_valid); else n_pass++;
    for (int i = 0; i < 20 && found < 2; i++) begin
      tick();
      if (obs_inst_valid) begin
        if (found == 0) begin
          n_checks++; if (obs_inst !== mem_word(30'h3FFF_FFFE)) $display("FAIL rr_inst: got %h want %h", obs_inst, mem_word(30'h3FFF_FFFE)); else n_pass++;
          n_checks++; if (obs_pc4 !== 30'h3FFF_FFFF) $display("FAIL rr_pc4: got %h want 3fffffff", obs_pc4); else n_pass++;
        end else begin
          n_checks++; if (obs_pc4 !== 30'h0) $display("FAIL rr_wrap_pc4: got %h want 0", obs_pc4); else n_pass++;
        end
        found++;
      end
    end
    if (found < 2) begin
      n_checks++;
      $display("FAIL rr_timeout: got %0d insts want 2", found);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      deq_ready      = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 4);
      redirect       = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFD : 30'($urandom);
      tick();
      n_checks++; if (obs_req_valid !== exp_req_valid) $display("FAIL rand_req_valid @%0d: got %b want %b", cyc, obs_req_valid, exp_req_valid); else n_pass++;
      if (exp_req_valid) begin
        n_checks++; if (obs_req_addr !== exp_req_addr) $display("FAIL rand_req_addr @%0d: got %h want %h", cyc, obs_req_addr, exp_req_addr); else n_pass++;
      end
      n_checks++; if (obs_inst_valid !== exp_inst_valid) $display("FAIL rand_inst_valid @%0d: got %b want %b", cyc, obs_inst_valid, exp_inst_valid); else n_pass++;
      n_checks++; if (obs_inst !== exp_inst) $display("FAIL rand_inst @%0d: got %h want %h", cyc, obs_inst, exp_inst); else n_pass++;
      n_checks++; if (obs_pc4 !== exp_pc4) $display("FAIL rand_pc4 @%0d: got %h want %h", cyc, obs_pc4, exp_pc4); else n_pass++;
    end
    redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    lat = 1;
    deq_ready = 1'b0;
    repeat (6) tick();
    n_checks++; if (obs_inst_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b want 1", obs_inst_valid); else n_pass++;
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL ar_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL ar_inst_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (inst !== 32'h0) $display("FAIL ar_inst: got %h want 0", inst); else n_pass++;
    n_checks++; if (inst_pc_plus4 !== 30'h0) $display("FAIL ar_pc4: got %h want 0", inst_pc_plus4); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b1;
    deq_ready = 1'b1;
    tick();
    n_checks++; if (obs_req_valid !== 1'b1) $display("FAIL ar_first_valid: got %b want 1", obs_req_valid); else n_pass++;
    n_checks++; if (obs_req_addr !== RESET_PC) $display("FAIL ar_first_addr: got %h want %h", obs_req_addr, RESET_PC); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_resp();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
